// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types: instruction classes, entry layout and sizing constants used by the
// reorder buffer, the reservation stations and the register file.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int ROB_IDX_W = 3;
    localparam int ROB_XLEN  = 32;

    typedef enum logic [3:0] {
        IT_ALU    = 4'd0,
        IT_LOAD   = 4'd1,
        IT_STORE  = 4'd2,
        IT_BRANCH = 4'd3,
        IT_JAL    = 4'd4,
        IT_JALR   = 4'd5,
        IT_MUL    = 4'd6,
        IT_DIV    = 4'd7,
        IT_NOP    = 4'd8
    } itype_e;

    typedef struct packed {
        logic                valid;
        logic                done;
        logic                mispredict;
        logic [4:0]          rd;
        itype_e              itype;
        logic [ROB_XLEN-1:0] value;
        logic [ROB_XLEN-1:0] target;
    } rob_entry_t;

    // Stores, branches and NOPs never produce a register result; x0 is never written.
    function automatic logic writes_rf(input itype_e itype, input logic [4:0] rd);
        return !(itype inside {IT_STORE, IT_BRANCH, IT_NOP}) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of the ROB's issue, CDB, operand-lookup, retirement and flush signals.
interface reorder_buffer_if #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int XLEN  = 32
);
    logic             alloc_valid_in;
    logic [4:0]       alloc_rd_in;
    logic [3:0]       alloc_itype_in;
    logic             ready_out;
    logic [IDX_W-1:0] alloc_idx_out;

    logic             cdb_valid_in;
    logic [IDX_W-1:0] cdb_rob_idx_in;
    logic [XLEN-1:0]  cdb_data_in;
    logic             cdb_mispredict_in;
    logic [XLEN-1:0]  cdb_target_in;

    logic [IDX_W-1:0] src1_idx_in;
    logic             src1_ready_out;
    logic [XLEN-1:0]  src1_value_out;
    logic [IDX_W-1:0] src2_idx_in;
    logic             src2_ready_out;
    logic [XLEN-1:0]  src2_value_out;

    logic             we_out;
    logic [4:0]       wa_out;
    logic [XLEN-1:0]  wd_out;
    logic [IDX_W-1:0] wrob_ix_out;
    logic             store_commit_out;
    logic             flush_out;
    logic [DEPTH-1:0] flush_addrs_out;
    logic [XLEN-1:0]  redirect_pc_out;

    modport master (
        output alloc_valid_in, alloc_rd_in, alloc_itype_in,
        output cdb_valid_in, cdb_rob_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
        output src1_idx_in, src2_idx_in,
        input  ready_out, alloc_idx_out,
        input  src1_ready_out, src1_value_out, src2_ready_out, src2_value_out,
        input  we_out, wa_out, wd_out, wrob_ix_out, store_commit_out,
        input  flush_out, flush_addrs_out, redirect_pc_out
    );

    modport slave (
        input  alloc_valid_in, alloc_rd_in, alloc_itype_in,
        input  cdb_valid_in, cdb_rob_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
        input  src1_idx_in, src2_idx_in,
        output ready_out, alloc_idx_out,
        output src1_ready_out, src1_value_out, src2_ready_out, src2_value_out,
        output we_out, wa_out, wd_out, wrob_ix_out, store_commit_out,
        output flush_out, flush_addrs_out, redirect_pc_out
    );

endinterface

// File: rtl/reorder_buffer_lookup_port.sv
// Combinational operand read of one ROB entry with same-cycle CDB bypass.
module reorder_buffer_lookup_port #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int XLEN  = 32
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [DEPTH-1:0] entry_done,
    input  logic [XLEN-1:0]  entry_value [DEPTH],
    input  logic             cdb_valid,
    input  logic [IDX_W-1:0] cdb_idx,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             ready,
    output logic [XLEN-1:0]  value
);

    logic cdb_hit;

    always_comb begin
        cdb_hit = cdb_valid && (cdb_idx == idx);
        ready   = entry_done[idx] || cdb_hit;
        // The bus carries the newest value, so it wins over the stored copy.
        value   = cdb_hit ? cdb_data : entry_value[idx];
    end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries at issue, records CDB completions and retires results
// to the register file in program order, flushing speculative state on a mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int IDX_W = ROB_IDX_W,
    parameter int XLEN  = ROB_XLEN
) (
    input  logic              clk_in,
    input  logic              rst_in,
    reorder_buffer_if.slave   bus
);

    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    rob_entry_t       entries [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;

    rob_entry_t       head_entry;
    logic             ready;
    logic             alloc_fire;
    logic             cdb_fire;
    logic             commit_fire;
    logic             commit_flush;
    logic [DEPTH-1:0] flush_mask;
    logic [DEPTH-1:0] done_vec;
    logic [XLEN-1:0]  value_arr [DEPTH];

    logic             we_p1;
    logic [4:0]       wa_p1;
    logic [XLEN-1:0]  wd_p1;
    logic [IDX_W-1:0] wrob_ix_p1;
    logic             store_commit_p1;
    logic             flush_p1;
    logic [DEPTH-1:0] flush_addrs_p1;
    logic [XLEN-1:0]  redirect_pc_p1;

    always_comb begin
        head_entry   = entries[head];
        commit_fire  = head_entry.valid && head_entry.done;
        commit_flush = commit_fire && head_entry.mispredict;
        // Occupancy comes from the registered count, so a retiring entry frees its slot next cycle.
        ready        = (count != FULL_CNT) && !flush_p1;
        alloc_fire   = bus.alloc_valid_in && ready && !commit_flush;
        cdb_fire     = bus.cdb_valid_in && entries[bus.cdb_rob_idx_in].valid && !commit_flush;
        for (int i = 0; i < DEPTH; i++) begin
            flush_mask[i] = entries[i].valid && (IDX_W'(i) != head);
            done_vec[i]   = entries[i].done;
            value_arr[i]  = entries[i].value;
        end
    end

    assign bus.ready_out     = ready;
    assign bus.alloc_idx_out = tail;

    reorder_buffer_lookup_port #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) u_lookup_src1 (
        .idx         (bus.src1_idx_in),
        .entry_done  (done_vec),
        .entry_value (value_arr),
        .cdb_valid   (bus.cdb_valid_in),
        .cdb_idx     (bus.cdb_rob_idx_in),
        .cdb_data    (bus.cdb_data_in),
        .ready       (bus.src1_ready_out),
        .value       (bus.src1_value_out)
    );

    reorder_buffer_lookup_port #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) u_lookup_src2 (
        .idx         (bus.src2_idx_in),
        .entry_done  (done_vec),
        .entry_value (value_arr),
        .cdb_valid   (bus.cdb_valid_in),
        .cdb_idx     (bus.cdb_rob_idx_in),
        .cdb_data    (bus.cdb_data_in),
        .ready       (bus.src2_ready_out),
        .value       (bus.src2_value_out)
    );

    // Entry state: only the status bits are reset; payload fields are qualified by valid.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid      <= 1'b0;
                entries[i].done       <= 1'b0;
                entries[i].mispredict <= 1'b0;
            end
        end else if (commit_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid      <= 1'b0;
                entries[i].done       <= 1'b0;
                entries[i].mispredict <= 1'b0;
            end
        end else begin
            if (alloc_fire) begin
                entries[tail].valid      <= 1'b1;
                entries[tail].done       <= (itype_e'(bus.alloc_itype_in) == IT_NOP);
                entries[tail].mispredict <= 1'b0;
                entries[tail].rd         <= bus.alloc_rd_in;
                entries[tail].itype      <= itype_e'(bus.alloc_itype_in);
            end
            if (cdb_fire) begin
                entries[bus.cdb_rob_idx_in].done       <= 1'b1;
                entries[bus.cdb_rob_idx_in].mispredict <= bus.cdb_mispredict_in;
                entries[bus.cdb_rob_idx_in].value      <= bus.cdb_data_in;
                entries[bus.cdb_rob_idx_in].target     <= bus.cdb_target_in;
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
                entries[head].done  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (commit_flush) begin
            // Only the retiring branch survives; everything younger is discarded.
            head  <= head + IDX_ONE;
            tail  <= head + IDX_ONE;
            count <= '0;
        end else begin
            if (alloc_fire)  tail <= tail + IDX_ONE;
            if (commit_fire) head <= head + IDX_ONE;
            count <= count + (IDX_W + 1)'(alloc_fire) - (IDX_W + 1)'(commit_fire);
        end
    end

    // ---- commit stage -> p1: registered retirement and flush outputs ----
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            we_p1           <= 1'b0;
            wa_p1           <= '0;
            wd_p1           <= '0;
            wrob_ix_p1      <= '0;
            store_commit_p1 <= 1'b0;
            flush_p1        <= 1'b0;
            flush_addrs_p1  <= '0;
            redirect_pc_p1  <= '0;
        end else begin
            we_p1           <= commit_fire && writes_rf(head_entry.itype, head_entry.rd);
            store_commit_p1 <= commit_fire && (head_entry.itype == IT_STORE);
            flush_p1        <= commit_flush;
            flush_addrs_p1  <= commit_flush ? flush_mask : '0;
            if (commit_fire) begin
                wa_p1      <= head_entry.rd;
                wd_p1      <= head_entry.value;
                wrob_ix_p1 <= head;
            end
            if (commit_flush) begin
                redirect_pc_p1 <= head_entry.target;
            end
        end
    end

    assign bus.we_out           = we_p1;
    assign bus.wa_out           = wa_p1;
    assign bus.wd_out           = wd_p1;
    assign bus.wrob_ix_out      = wrob_ix_p1;
    assign bus.store_commit_out = store_commit_p1;
    assign bus.flush_out        = flush_p1;
    assign bus.flush_addrs_out  = flush_addrs_p1;
    assign bus.redirect_pc_out  = redirect_pc_p1;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed-vector bench for reorder_buffer: allocation, completion, in-order commit,
// full/wrap behaviour, mispredict flush and operand lookup bypass.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int XLEN  = 32;

    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    reorder_buffer_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) rob_if ();

    reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (rob_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rob_if.alloc_valid_in    = 1'b0;
        rob_if.alloc_rd_in       = '0;
        rob_if.alloc_itype_in    = '0;
        rob_if.cdb_valid_in      = 1'b0;
        rob_if.cdb_rob_idx_in    = '0;
        rob_if.cdb_data_in       = '0;
        rob_if.cdb_mispredict_in = 1'b0;
        rob_if.cdb_target_in     = '0;
        rob_if.src1_idx_in       = '0;
        rob_if.src2_idx_in       = '0;
    endtask

    task automatic apply_reset(input string tag);
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq({tag, "_ready"},     64'(rob_if.ready_out),        64'd1);
        check_eq({tag, "_alloc_idx"}, 64'(rob_if.alloc_idx_out),    64'd0);
        check_eq({tag, "_we"},        64'(rob_if.we_out),           64'd0);
        check_eq({tag, "_flush"},     64'(rob_if.flush_out),        64'd0);
        check_eq({tag, "_store"},     64'(rob_if.store_commit_out), 64'd0);
    endtask

    task automatic alloc(input logic [4:0] rd, input itype_e it);
        rob_if.alloc_valid_in = 1'b1;
        rob_if.alloc_rd_in    = rd;
        rob_if.alloc_itype_in = it;
        tick();
        rob_if.alloc_valid_in = 1'b0;
    endtask

    task automatic cdb(input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] data,
                       input logic mis, input logic [XLEN-1:0] tgt);
        rob_if.cdb_valid_in      = 1'b1;
        rob_if.cdb_rob_idx_in    = idx;
        rob_if.cdb_data_in       = data;
        rob_if.cdb_mispredict_in = mis;
        rob_if.cdb_target_in     = tgt;
        tick();
        rob_if.cdb_valid_in      = 1'b0;
        rob_if.cdb_mispredict_in = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        clear_inputs();
        apply_reset("rst0");

        // Single ADD: done one edge after CDB, retired the edge after that.
        alloc(5'd5, IT_ALU);
        check_eq("t1_alloc_idx", 64'(rob_if.alloc_idx_out), 64'd1);
        cdb(3'd0, 32'h2A, 1'b0, 32'h0);
        check_eq("t1_we_early", 64'(rob_if.we_out), 64'd0);
        tick();
        check_eq("t1_we",   64'(rob_if.we_out),      64'd1);
        check_eq("t1_wa",   64'(rob_if.wa_out),      64'd5);
        check_eq("t1_wd",   64'(rob_if.wd_out),      64'h2A);
        check_eq("t1_wrob", 64'(rob_if.wrob_ix_out), 64'd0);
        tick();
        check_eq("t1_we_off", 64'(rob_if.we_out), 64'd0);

        // Out-of-order completion, in-order retirement.
        apply_reset("rst1");
        alloc(5'd1, IT_ALU);
        alloc(5'd2, IT_MUL);
        alloc(5'd3, IT_LOAD);
        cdb(3'd2, 32'h33, 1'b0, 32'h0);
        cdb(3'd1, 32'h22, 1'b0, 32'h0);
        cdb(3'd0, 32'h11, 1'b0, 32'h0);
        check_eq("t2_no_commit_yet", 64'(rob_if.we_out), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("t2_we%0d", k),   64'(rob_if.we_out),      64'd1);
            check_eq($sformatf("t2_wrob%0d", k), 64'(rob_if.wrob_ix_out), 64'(k));
            check_eq($sformatf("t2_wa%0d", k),   64'(rob_if.wa_out),      64'(k + 1));
            check_eq($sformatf("t2_wd%0d", k),   64'(rob_if.wd_out),      64'(32'h11 * (k + 1)));
        end
        tick();
        check_eq("t2_we_off", 64'(rob_if.we_out), 64'd0);

        // Fill, ignore overflow, retire one, tail wraps.
        apply_reset("rst2");
        for (int k = 0; k < DEPTH; k++) alloc(5'(8 + k), IT_ALU);
        check_eq("t3_full_ready", 64'(rob_if.ready_out),     64'd0);
        check_eq("t3_full_tail",  64'(rob_if.alloc_idx_out), 64'd0);
        alloc(5'd30, IT_ALU);
        check_eq("t3_ovf_ready", 64'(rob_if.ready_out),     64'd0);
        check_eq("t3_ovf_tail",  64'(rob_if.alloc_idx_out), 64'd0);
        rob_if.alloc_valid_in = 1'b1;
        rob_if.alloc_rd_in    = 5'd20;
        rob_if.alloc_itype_in = IT_ALU;
        cdb(3'd0, 32'h80, 1'b0, 32'h0);
        check_eq("t3_done_ready", 64'(rob_if.ready_out), 64'd0);
        tick();
        check_eq("t3_ret_we",    64'(rob_if.we_out),        64'd1);
        check_eq("t3_ret_wa",    64'(rob_if.wa_out),        64'd8);
        check_eq("t3_ret_wd",    64'(rob_if.wd_out),        64'h80);
        check_eq("t3_ret_ready", 64'(rob_if.ready_out),     64'd1);
        check_eq("t3_ret_tail",  64'(rob_if.alloc_idx_out), 64'd0);
        tick();
        rob_if.alloc_valid_in = 1'b0;
        check_eq("t3_wrap_ready", 64'(rob_if.ready_out),     64'd0);
        check_eq("t3_wrap_tail",  64'(rob_if.alloc_idx_out), 64'd1);
        apply_reset("rst_mid");

        // Branch mispredict at idx1 with idx2..4 in flight.
        alloc(5'd1, IT_ALU);
        alloc(5'd0, IT_BRANCH);
        alloc(5'd2, IT_ALU);
        alloc(5'd3, IT_ALU);
        alloc(5'd4, IT_ALU);
        cdb(3'd0, 32'h10, 1'b0, 32'h0);
        cdb(3'd1, 32'h0, 1'b1, 32'h100);
        check_eq("t4_pre_we", 64'(rob_if.we_out), 64'd1);
        check_eq("t4_pre_wd", 64'(rob_if.wd_out), 64'h10);
        rob_if.alloc_valid_in = 1'b1;
        rob_if.alloc_rd_in    = 5'd9;
        rob_if.alloc_itype_in = IT_ALU;
        tick();
        rob_if.alloc_valid_in = 1'b0;
        check_eq("t4_flush",    64'(rob_if.flush_out),       64'd1);
        check_eq("t4_mask",     64'(rob_if.flush_addrs_out), 64'b0001_1100);
        check_eq("t4_redirect", 64'(rob_if.redirect_pc_out), 64'h100);
        check_eq("t4_we_br",    64'(rob_if.we_out),          64'd0);
        check_eq("t4_wrob",     64'(rob_if.wrob_ix_out),     64'd1);
        check_eq("t4_ready",    64'(rob_if.ready_out),       64'd0);
        check_eq("t4_tail",     64'(rob_if.alloc_idx_out),   64'd2);
        tick();
        check_eq("t4_flush_off", 64'(rob_if.flush_out),       64'd0);
        check_eq("t4_mask_off",  64'(rob_if.flush_addrs_out), 64'd0);
        check_eq("t4_ready2",    64'(rob_if.ready_out),       64'd1);
        check_eq("t4_tail2",     64'(rob_if.alloc_idx_out),   64'd2);

        // Lookup bypass, x0 destination and store retirement.
        apply_reset("rst3");
        alloc(5'd0, IT_ALU);
        alloc(5'd0, IT_ALU);
        alloc(5'd7, IT_STORE);
        alloc(5'd0, IT_ALU);
        rob_if.src1_idx_in = 3'd3;
        rob_if.src2_idx_in = 3'd2;
        #1;
        check_eq("t5_src1_nrdy", 64'(rob_if.src1_ready_out), 64'd0);
        rob_if.cdb_valid_in   = 1'b1;
        rob_if.cdb_rob_idx_in = 3'd3;
        rob_if.cdb_data_in    = 32'h77;
        #1;
        check_eq("t5_byp_rdy",  64'(rob_if.src1_ready_out), 64'd1);
        check_eq("t5_byp_val",  64'(rob_if.src1_value_out), 64'h77);
        check_eq("t5_src2_nrdy", 64'(rob_if.src2_ready_out), 64'd0);
        tick();
        rob_if.cdb_valid_in = 1'b0;
        #1;
        check_eq("t5_held_rdy", 64'(rob_if.src1_ready_out), 64'd1);
        check_eq("t5_held_val", 64'(rob_if.src1_value_out), 64'h77);
        cdb(3'd0, 32'h1, 1'b0, 32'h0);
        cdb(3'd1, 32'h2, 1'b0, 32'h0);
        cdb(3'd2, 32'h3, 1'b0, 32'h0);
        check_eq("t5_src2_rdy", 64'(rob_if.src2_ready_out), 64'd1);
        check_eq("t5_src2_val", 64'(rob_if.src2_value_out), 64'h3);
        check_eq("t5_x0_we",    64'(rob_if.we_out),         64'd0);
        check_eq("t5_x0_wrob",  64'(rob_if.wrob_ix_out),    64'd1);
        tick();
        check_eq("t5_st_pulse", 64'(rob_if.store_commit_out), 64'd1);
        check_eq("t5_st_we",    64'(rob_if.we_out),           64'd0);
        check_eq("t5_st_wrob",  64'(rob_if.wrob_ix_out),      64'd2);
        tick();
        check_eq("t5_st_end",   64'(rob_if.store_commit_out), 64'd0);
        check_eq("t5_last_we",  64'(rob_if.we_out),           64'd0);
        check_eq("t5_last_wrob", 64'(rob_if.wrob_ix_out),     64'd3);
        check_eq("t5_last_wd",  64'(rob_if.wd_out),           64'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
